// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : updown_mod_counter
// Purpose  : Parametrised up/down modulo counter with a run-time programmable
//            terminal value (limit), wrap or saturate behaviour, cascade
//            carry-in/carry-out and a sticky overflow flag.
// Ports    : clk      - clock, all state changes on the rising edge
//            mr       - master reset, synchronous, active-high
//            load     - q <= d (beats counting, loses to mr)
//            d        - parallel load value
//            limit_wr - limit <= limit_d (independent of load/count)
//            limit_d  - new terminal value
//            en, ci   - a count step needs en & ci
//            up       - 1 = count up, 0 = count down
//            ovf_clr  - clears ovf (a same-cycle set wins)
//            q        - counter value
//            tc       - terminal: up ? q >= limit : q == 0
//            co       - cascade carry out = en & ci & tc
//            ovf      - sticky overflow, set on every terminal step
// Revision : 1.0 - initial release
// ============================================================================
module updown_mod_counter #(
  parameter int                WIDTH     = 4,
  parameter logic [WIDTH-1:0]  LIMIT_RST = {WIDTH{1'b1}},
  parameter bit                SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             mr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             limit_wr,
  input  logic [WIDTH-1:0] limit_d,
  input  logic             en,
  input  logic             ci,
  input  logic             up,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             co,
  output logic             ovf
);

  logic [WIDTH-1:0] q_q,   q_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             ovf_q, ovf_d;
  logic             w_step;

  // Terminal uses >= so a value above the limit (after a load or a limit
  // write) is treated as terminal and wraps to 0 on the next up step.
  assign tc     = up ? (q_q >= lim_q) : (q_q == '0);
  assign w_step = en & ci;
  assign co     = w_step & tc;

  assign q   = q_q;
  assign ovf = ovf_q;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (w_step) begin
      if (up) begin
        if (tc) begin
          q_d = SATURATE ? q_q : '0;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (tc) begin
          q_d = SATURATE ? q_q : lim_q;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  // The count step above always sees the current limit; a write lands for
  // the following cycle.
  always_comb begin
    lim_d = lim_q;
    if (limit_wr) begin
      lim_d = limit_d;
    end
  end

  // Clear first so that a terminal step in the same cycle wins.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (!load && w_step && tc) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mr) begin
      q_q   <= '0;
      lim_q <= LIMIT_RST;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      lim_q <= lim_d;
      ovf_q <= ovf_d;
    end
  end

endmodule
`default_nettype wire
